// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: I2C slave exposing a small register file.
//   Register 0 is read-only and reflects Temp live; registers 1..NUM_REGS-1
//   are read/write. The first data byte of a write selects the pointer.
//   Multi-byte registers are transferred MSB byte first.
// Ports:
//   Clk    - system clock; all logic runs on its rising edge
//   Rst    - synchronous active-high reset
//   Scl    - I2C clock, asynchronous to Clk
//   Sda    - I2C data, open-drain (driven low or released)
//   Temp   - live value of read-only register 0
//   Regs   - registers 1..NUM_REGS-1 flattened, register 1 in the LSBs
//   Wr_stb - one-Clk pulse when a register write commits
//   Busy   - high from the address ACK until STOP, repeated START or NACK
module i2c_reg_slave #(
  parameter logic [6:0]             DEV_ADDR  = 7'b1001000,
  parameter int unsigned            NUM_REGS  = 4,
  parameter int unsigned            REG_BYTES = 2,
  parameter int unsigned            AUTO_INC  = 1,
  parameter logic [REG_BYTES*8-1:0] RST_VAL   = '0
) (
  input  logic                                 Clk,
  input  logic                                 Rst,
  input  logic                                 Scl,
  inout  wire                                  Sda,
  input  logic [REG_BYTES*8-1:0]               Temp,
  output logic [(NUM_REGS-1)*REG_BYTES*8-1:0]  Regs,
  output logic                                 Wr_stb,
  output logic                                 Busy
);

  localparam int unsigned W  = REG_BYTES * 8;
  localparam int unsigned PW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t                        state;
  logic                          scl_s1, scl_s2, scl_d;
  logic                          sda_s1, sda_s2, sda_d;
  logic [3:0]                    bit_cnt;
  logic [6:0]                    shift;
  logic                          rw;
  logic [PW-1:0]                 ptr;
  logic [1:0]                    byte_idx;
  logic [W-1:0]                  shadow;
  logic [W-1:0]                  snap;
  logic [6:0]                    tx;
  logic                          sda_oe;
  logic [(NUM_REGS-1)*W-1:0]     regs_q;

  logic                          scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]                    rx_byte;
  logic [W-1:0]                  cur_val;
  logic [7:0]                    snap_byte;
  logic [7:0]                    load_byte;
  logic                          last_byte;

  assign Sda  = sda_oe ? 1'b0 : 1'bz;
  assign Regs = regs_q;

  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
  assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;
  assign rx_byte   = {shift, sda_s2};
  assign last_byte = (byte_idx == 2'(REG_BYTES - 1));

  // Register currently addressed by the pointer (Temp for pointer 0).
  always_comb begin
    cur_val = Temp;
    for (int unsigned i = 1; i < NUM_REGS; i++)
      if (ptr == PW'(i)) cur_val = regs_q[(i-1)*W +: W];
  end

  always_comb begin
    snap_byte = snap[W-1 -: 8];
    for (int unsigned i = 0; i < REG_BYTES; i++)
      if (byte_idx == 2'(i)) snap_byte = snap[(REG_BYTES-1-i)*8 +: 8];
  end

  // Byte index 0 starts a fresh register: take it live and snapshot it so
  // the remaining bytes stay coherent even if the source changes.
  assign load_byte = (byte_idx == 2'd0) ? cur_val[W-1 -: 8] : snap_byte;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_d    <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_d    <= 1'b1;
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      rw       <= 1'b0;
      ptr      <= '0;
      byte_idx <= '0;
      shadow   <= '0;
      snap     <= '0;
      tx       <= '0;
      sda_oe   <= 1'b0;
      regs_q   <= {(NUM_REGS-1){RST_VAL}};
      Wr_stb   <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      scl_s1 <= Scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= Sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
      Wr_stb <= 1'b0;

      if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        byte_idx <= '0;
        sda_oe   <= 1'b0;
        Busy     <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        Busy   <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                rw <= rx_byte[0];
                if (rx_byte[7:1] != DEV_ADDR) state <= IDLE;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe  <= 1'b1;
              bit_cnt <= '0;
              Busy    <= 1'b1;
              state   <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                state  <= RDATA;
                snap   <= cur_val;
                tx     <= load_byte[6:0];
                sda_oe <= ~load_byte[7];
              end else begin
                sda_oe <= 1'b0;
                state  <= PTR;
              end
            end
          end
          PTR: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) ptr <= rx_byte[PW-1:0];
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe  <= 1'b1;
              bit_cnt <= '0;
              state   <= PTR_ACK;
            end
          end
          PTR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WDATA;
            end
          end
          WDATA: begin
            if (scl_rise) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) shadow <= W'({shadow, rx_byte});
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe  <= 1'b1;
              bit_cnt <= '0;
              state   <= WDATA_ACK;
            end
          end
          WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WDATA;
              if (last_byte) begin
                byte_idx <= '0;
                // Pointer 0 matches no writable slot, so the data is dropped.
                for (int unsigned i = 1; i < NUM_REGS; i++)
                  if (ptr == PW'(i)) regs_q[(i-1)*W +: W] <= shadow;
                if (ptr != '0) Wr_stb <= 1'b1;
                if (AUTO_INC == 1) ptr <= ptr + 1'b1;
              end else begin
                byte_idx <= byte_idx + 2'd1;
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= RDATA_ACK;
              end else begin
                sda_oe <= ~tx[6];
                tx     <= {tx[5:0], 1'b0};
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                state <= IDLE;
                Busy  <= 1'b0;
              end else if (last_byte) begin
                byte_idx <= '0;
                if (AUTO_INC == 1) ptr <= ptr + 1'b1;
              end else begin
                byte_idx <= byte_idx + 2'd1;
              end
            end else if (scl_fall) begin
              // Pointer/index were advanced on the ACK rise, so the load
              // here already sees the next byte or the next register.
              state <= RDATA;
              if (byte_idx == 2'd0) snap <= cur_val;
              tx     <= load_byte[6:0];
              sda_oe <= ~load_byte[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb_i2c_reg_slave: bus-level master driving i2c_reg_slave, with a
// register-file reference model and scoreboard queues for commits and
// read bytes.
module tb_i2c_reg_slave;

  localparam int          NR = 4;
  localparam int          RB = 2;
  localparam int          W  = RB * 8;
  localparam logic [W-1:0] RV = 16'hA55A;
  localparam int          Q  = 80;

  typedef struct {
    int           idx;
    logic [W-1:0] val;
  } wr_t;

  logic                Clk = 1'b0;
  logic                Rst;
  logic                Scl;
  logic                m_low;
  logic [W-1:0]        Temp;
  logic [(NR-1)*W-1:0] Regs;
  logic                Wr_stb;
  logic                Busy;
  wire                 sda_w;

  pullup (sda_w);
  assign sda_w = m_low ? 1'b0 : 1'bz;

  i2c_reg_slave #(
    .DEV_ADDR (7'b1001000),
    .NUM_REGS (NR),
    .REG_BYTES(RB),
    .AUTO_INC (1),
    .RST_VAL  (RV)
  ) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Scl   (Scl),
    .Sda   (sda_w),
    .Temp  (Temp),
    .Regs  (Regs),
    .Wr_stb(Wr_stb),
    .Busy  (Busy)
  );

  always #5 Clk = ~Clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_stb    = 0;
  int           stb_exp  = 0;
  logic [W-1:0] mdl [NR];
  int           mptr;
  logic [W-1:0] t_next;
  wr_t          exp_wr[$];
  logic [7:0]   exp_rd[$];
  logic [7:0]   obs_q[$];
  event         obs_ev;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [(NR-1)*W-1:0] model_regs();
    logic [(NR-1)*W-1:0] v;
    for (int i = 1; i < NR; i++) v[(i-1)*W +: W] = mdl[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 1; i < NR; i++) mdl[i] = RV;
    mptr = 0;
  endfunction

  // Commit monitor.
  always @(negedge Clk) begin
    if (Wr_stb) begin
      wr_t e;
      n_stb++;
      chk("wr_stb_expected", exp_wr.size() > 0, 1);
      if (exp_wr.size() > 0) begin
        e = exp_wr.pop_front();
        chk("wr_commit_val", Regs[(e.idx-1)*W +: W], e.val);
      end
    end
  end

  // Read-byte scoreboard.
  initial begin
    forever begin
      @(obs_ev);
      while (obs_q.size() > 0) begin
        logic [7:0] o;
        o = obs_q.pop_front();
        chk("rd_exp_available", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) chk("rd_byte", o, exp_rd.pop_front());
      end
    end
  end

  task automatic bus_start();
    m_low = 1'b0; #(Q);
    Scl   = 1'b1; #(Q);
    m_low = 1'b1; #(Q);
    Scl   = 1'b0; #(Q);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #(Q);
    Scl   = 1'b1; #(Q);
    m_low = 1'b0; #(Q);
  endtask

  task automatic bit_slot(input logic b, output logic s);
    m_low = ~b; #(Q);
    Scl   = 1'b1; #(Q);
    s     = sda_w; #(Q);
    Scl   = 1'b0; #(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_slot(b[i], s);
    bit_slot(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) bit_slot(1'b1, d[i]);
    bit_slot(~ack, s);
  endtask

  task automatic post_checks(input string tag);
    #(Q);
    chk({tag, "_busy_idle"}, Busy, 0);
    chk({tag, "_regs"}, Regs, model_regs());
    chk({tag, "_stb_count"}, n_stb, stb_exp);
  endtask

  task automatic do_write(input logic [7:0] pb, input logic [7:0] d[$],
                          input string tag);
    logic         ack;
    logic [W-1:0] sh = '0;
    int           cnt = 0;
    bus_start();
    write_byte(8'h90, ack);
    chk({tag, "_addr_ack"}, ack, 1);
    chk({tag, "_busy"}, Busy, 1);
    write_byte(pb, ack);
    chk({tag, "_ptr_ack"}, ack, 1);
    mptr = pb % NR;
    foreach (d[i]) begin
      sh = W'({sh, d[i]});
      cnt++;
      if (cnt == RB) begin
        if (mptr != 0) begin
          mdl[mptr] = sh;
          exp_wr.push_back('{idx: mptr, val: sh});
          stb_exp++;
        end
        mptr = (mptr + 1) % NR;
        cnt  = 0;
      end
      write_byte(d[i], ack);
      chk({tag, "_data_ack"}, ack, 1);
    end
    bus_stop();
    post_checks(tag);
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] pb, input int n,
                         input bit tchg, input logic [W-1:0] tnew,
                         input string tag);
    logic         ack;
    logic [7:0]   d;
    logic [W-1:0] snap = '0;
    int           bidx = 0;
    bus_start();
    if (set_ptr) begin
      write_byte(8'h90, ack);
      chk({tag, "_addr_w_ack"}, ack, 1);
      write_byte(pb, ack);
      chk({tag, "_ptr_ack"}, ack, 1);
      mptr = pb % NR;
      bus_start();
    end
    write_byte(8'h91, ack);
    chk({tag, "_addr_r_ack"}, ack, 1);
    chk({tag, "_busy"}, Busy, 1);
    for (int k = 0; k < n; k++) begin
      if (bidx == 0) snap = (mptr == 0) ? Temp : mdl[mptr];
      exp_rd.push_back(8'(snap >> ((RB - 1 - bidx) * 8)));
      if (tchg && k == 0) begin
        t_next = tnew;
        fork
          begin
            #(Q * 16);
            Temp = t_next;
          end
        join_none
      end
      read_byte(k < n - 1, d);
      obs_q.push_back(d);
      ->obs_ev;
      if (k < n - 1) begin
        bidx++;
        if (bidx == RB) begin
          bidx = 0;
          mptr = (mptr + 1) % NR;
        end
      end
    end
    chk({tag, "_nack_busy"}, Busy, 0);
    chk({tag, "_nack_sda"}, sda_w, 1);
    bus_stop();
    post_checks(tag);
  endtask

  initial begin
    logic       ack;
    logic [7:0] q[$];
    logic [7:0] pb;

    Rst = 1'b1; Scl = 1'b1; m_low = 1'b0; Temp = '0;
    model_reset();
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    chk("rst_regs", Regs, {(NR-1){RV}});
    chk("rst_busy", Busy, 0);
    chk("rst_wr_stb", Wr_stb, 0);
    chk("rst_sda", sda_w, 1);
    Rst = 1'b0;
    #(Q);

    // Directed write to register 1, then read back via the advanced pointer.
    q = '{8'hAB, 8'hCD};
    do_write(8'h01, q, "w_reg1");
    chk("w_reg1_value", Regs[W-1:0], 16'hABCD);
    do_read(1'b0, 8'h00, 2, 1'b0, '0, "r_ptr2");

    // Read of the live register 0 through a repeated START.
    Temp = 16'h1960;
    do_read(1'b1, 8'h00, 2, 1'b0, '0, "r_temp");

    // Foreign address: no ACK, not busy, line left released.
    bus_start();
    write_byte(8'h92, ack);
    chk("foreign_nack", ack, 0);
    chk("foreign_busy", Busy, 0);
    write_byte(8'h00, ack);
    chk("foreign_sda_free", ack, 0);
    bus_stop();
    post_checks("foreign");

    // Partial write is discarded.
    q = '{8'h55};
    do_write(8'h03, q, "partial");

    // Temp changes mid-register; the snapshot must hold.
    Temp = 16'h1960;
    do_read(1'b1, 8'h00, 2, 1'b1, 16'h1A00, "r_snap");

    // Writes to register 0 are dropped.
    q = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_write(8'h00, q, "w_ptr0");

    // Randomised transactions.
    for (int t = 0; t < 18; t++) begin
      Temp = W'($urandom);
      pb   = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        q = {};
        for (int b = 0; b < int'($urandom_range(0, 6)); b++) q.push_back(8'($urandom));
        do_write(pb, q, "rand_w");
      end else begin
        do_read($urandom_range(0, 3) != 0, pb, int'($urandom_range(1, 5)),
                1'b0, '0, "rand_r");
      end
    end

    // Reset while the slave holds a data ACK.
    bus_start();
    write_byte(8'h90, ack);
    chk("rst_mid_addr_ack", ack, 1);
    write_byte(8'h01, ack);
    chk("rst_mid_ptr_ack", ack, 1);
    for (int i = 7; i >= 0; i--) begin
      logic s;
      bit_slot(1'b0, s);
    end
    m_low = 1'b0;
    #(Q);
    chk("rst_mid_ack_drive", sda_w, 0);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_mid_sda_free", sda_w, 1);
    @(negedge Clk);
    Rst = 1'b0;
    model_reset();
    chk("rst_mid_regs", Regs, model_regs());
    chk("rst_mid_busy", Busy, 0);
    Scl = 1'b1; #(2 * Q);
    Scl = 1'b0; #(Q);
    bus_stop();
    post_checks("rst_mid");

    q = '{8'hC3, 8'h3C};
    do_write(8'h02, q, "post_rst_w");
    do_read(1'b1, 8'h02, 2, 1'b0, '0, "post_rst_r");

    #(4 * Q);
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #(20_000_000);
    n_fail++;
    $display("FAIL timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/i2c_reg_slave.md
I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 The parameter DEV_ADDR SHALL default to 7'b1001000 and set the 7-bit I2C device address.
REQ-002 The parameter NUM_REGS SHALL default to 4 and set the number of registers; it SHALL be a power of 2 and at least 2.
REQ-003 The parameter REG_BYTES SHALL default to 2 and set the bytes per register, in the range 1-4.
REQ-004 The parameter AUTO_INC SHALL default to 1; when it is 1 the pointer increments after each completed register access.
REQ-005 The parameter RST_VAL SHALL default to 0 and set the reset value of registers 1..NUM_REGS-1.
REQ-006 Port Clk SHALL be an input, 1 bit wide: the system clock, with all logic on its rising edge.
REQ-007 Port Rst SHALL be an input, 1 bit wide: the reset, synchronous and active-high.
REQ-008 Port Scl SHALL be an input, 1 bit wide: the I2C clock, asynchronous to Clk.
REQ-009 Port Sda SHALL be an inout, 1 bit wide: I2C data, open-drain, driven only low and otherwise high-Z.
REQ-010 Port Temp SHALL be an input, REG_BYTES*8 bits wide: the live value of read-only register 0.
REQ-011 Port Regs SHALL be an output, (NUM_REGS-1)*REG_BYTES*8 bits wide: registers 1..NUM_REGS-1 flattened, with register 1 in the LSBs.
REQ-012 Port Wr_stb SHALL be an output, 1 bit wide: a one-Clk pulse when a register write commits.
REQ-013 Port Busy SHALL be an output, 1 bit wide: high while the block is addressed, from address ACK until STOP, repeated START, or NACK.

Function
REQ-014 Scl and Sda SHALL each pass through a 2-flop synchroniser followed by an edge-detect flop before any use.
REQ-015 START SHALL be detected as a synchronised Sda fall while Scl is high, and STOP as an Sda rise while Scl is high; both SHALL be honoured in any state.
REQ-016 The FSM SHALL have the states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, and RDATA_ACK.
REQ-017 A START SHALL move the FSM to ADDR and clear the bit counter and byte index, whether it is a first START or a repeated START.
REQ-018 A STOP SHALL move the FSM to IDLE and release Sda.
REQ-019 Input bits SHALL be sampled on the synchronised Scl rising edge, MSB first.
REQ-020 Sda drive changes SHALL occur only on the synchronised Scl falling edge.
REQ-021 In ADDR, if the 7 address bits after the START do not equal DEV_ADDR, the FSM SHALL return to IDLE without ACK.
REQ-022 ACK SHALL be driven by asserting the Sda low drive from the Scl fall after bit 8 until the Scl fall after bit 9.
REQ-023 After the address ACK, R/W=0 SHALL lead to PTR and R/W=1 SHALL lead to RDATA.
REQ-024 PTR SHALL store the low log2(NUM_REGS) bits of the received byte as the pointer, ignore the upper bits, and always ACK.
REQ-025 After PTR_ACK, data bytes SHALL be written MSB byte first into a shadow buffer, with every byte ACKed.
REQ-026 When the last byte of a REG_BYTES-byte write is ACKed, the shadow buffer SHALL commit to the register at the pointer and Wr_stb SHALL pulse.
REQ-027 After a commit, the pointer SHALL increment modulo NUM_REGS if AUTO_INC is 1.
REQ-028 Writes to pointer 0 SHALL be ACKed but discarded, and Wr_stb SHALL not pulse.
REQ-029 A STOP or START arriving before all REG_BYTES bytes of a write SHALL discard the partial shadow contents and leave the register unchanged.
REQ-030 On entering RDATA at byte index 0, the selected register SHALL be snapshotted (Temp for pointer 0) so that multi-byte reads are coherent.
REQ-031 In RDATA the block SHALL drive each snapshot bit low when the bit is 0 and release Sda when it is 1, MSB byte first.
REQ-032 In RDATA_ACK the block SHALL release Sda and sample the master's ACK bit.
REQ-033 If the master ACKs, the next byte SHALL be sent; after the last byte of a register the pointer SHALL advance (when AUTO_INC is 1) and a new snapshot SHALL be taken.
REQ-034 If the master NACKs, the block SHALL release Sda and wait in IDLE for the next START.
REQ-035 The bit counter SHALL be 4 bits, count 0-8, and wrap to 0 on every ACK slot.

Reset
REQ-036 When Rst=1 at a Clk edge: FSM to IDLE, Sda released, pointer=0, byte index=0, registers 1..N-1 = RST_VAL, Wr_stb=0, Busy=0, synchroniser flops=1.
REQ-037 A reset asserted mid-transfer SHALL release Sda by the next Clk edge; the bus SHALL be ignored until a new START.

Verification
REQ-038 Scenario: write 0x90 (address + W), 0x01, 0xAB, 0xCD, STOP -> 4 ACKs, Wr_stb pulses once, Regs[15:0]=16'hABCD, pointer=2.
REQ-039 Scenario: Temp=16'h1960, write 0x90, 0x00, repeated START, 0x91, master ACK then NACK -> bytes read are 0x19 and 0x60, then Sda released.
REQ-040 Scenario: send address 0x92 -> no ACK, Busy stays 0, Sda stays high-Z until STOP.
REQ-041 Scenario: write 0x90, 0x03, 0x55, then STOP -> register 3 unchanged and no Wr_stb pulse.
REQ-042 Scenario: Temp changes 0x1960->0x1A00 between MSB and LSB during a read -> bytes read are 0x19, 0x60.
REQ-043 Scenario: Rst pulsed during a data ACK -> Sda high-Z next Clk, all registers = RST_VAL, and the next full transaction succeeds.
